// File: rtl/axi_stream_mac_arbiter_if.sv
// axi_stream_mac_arbiter_if: per-source stream inputs and shared datapath output of the MAC arbiter
interface axi_stream_mac_arbiter_if #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] s_valid;
    logic [NUM_REQ-1:0] s_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0] s_ready;
    logic m_valid;
    logic m_last;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ID_W-1:0] m_id;
    logic m_ready;
    modport slave (
        input  s_valid, s_last, s_data, m_ready,
        output s_ready, m_valid, m_last, m_data, m_id
    );
    modport master (
        output s_valid, s_last, s_data, m_ready,
        input  s_ready, m_valid, m_last, m_data, m_id
    );
endinterface

// File: rtl/axi_stream_mac_arbiter.sv
// axi_stream_mac_arbiter: message-granular round-robin stream arbiter; ARB_WATCHDOG_EN adds a stalled-source abort
module axi_stream_mac_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    axi_stream_mac_arbiter_if.slave bus,
    output logic busy,
    output logic [15:0] beat_cnt,
    output logic timeout_err
);
    localparam int ID_W = $clog2(NUM_REQ);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] grant, last_grant, pick, idx;
    logic found, acc, done, abort;
    always_comb begin
        pick = last_grant;
        found = 1'b0;
        idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && bus.s_valid[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        bus.s_ready = '0;
        bus.s_ready[grant] = (state == STREAM) && bus.m_ready;
        bus.m_valid = (state == STREAM) && bus.s_valid[grant];
        bus.m_last = (state == STREAM) && bus.s_last[grant];
        bus.m_data = bus.s_data[grant*DATA_WIDTH +: DATA_WIDTH];
        bus.m_id = grant;
        acc = bus.m_valid && bus.m_ready;
        done = acc && bus.m_last;
        state_nxt = (state == IDLE) ? (found ? STREAM : IDLE) : ((done || abort) ? IDLE : STREAM);
    end
    assign busy = (state == STREAM);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            grant <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && found) grant <= pick;
            if (done || abort) begin
                last_grant <= grant;
                beat_cnt <= '0;
            end else if (acc && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
        end
`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    // only cycles where the granted source itself is idle count; downstream backpressure does not
    assign abort = (state == STREAM) && !bus.s_valid[grant] && (wd == WD_W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wd <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            wd <= (state == STREAM && !bus.s_valid[grant] && !abort) ? wd + 1'b1 : '0;
        end
`else
    assign abort = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule
